// File: rtl/mdma_write_sched.sv
// mdma_write_sched
// Splits one MDMA write descriptor (start address + beat count) into AXI
// bursts of at most 16 beats that never cross a 4 KB boundary. A burst is
// launched only when the single write engine is free and the write FIFO
// already holds the whole burst. B-channel responses are counted so that
// done is reported only after every issued burst has been acknowledged.
//
// Ports
//   aclk, areset    clock, asynchronous active-high reset
//   start           one-cycle descriptor strobe (looked at only when idle)
//   start_addr      first byte address, 8-byte aligned
//   total_beats     number of 64-bit beats in the descriptor
//   busy            descriptor in progress
//   done            one-cycle completion pulse
//   err             sticky error, set by any non-OKAY bresp
//   eng_valid       one-cycle burst launch strobe to the write engine
//   eng_head_addr   burst start address (holds after the launch)
//   eng_burst_len   burst length 1..16 (holds after the launch)
//   eng_free        write engine idle
//   fifo_level      beats currently held in the write FIFO
//   bvalid, bresp   write response channel (engine keeps bready high)
module mdma_write_sched #(
   parameter int ADDR_W = 32,
   parameter int LEN_W  = 16,
   parameter int LVL_W  = 8
) (
   input  logic              aclk,
   input  logic              areset,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  total_beats,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              eng_valid,
   output logic [ADDR_W-1:0] eng_head_addr,
   output logic [4:0]        eng_burst_len,
   input  logic              eng_free,
   input  logic [LVL_W-1:0]  fifo_level,
   input  logic              bvalid,
   input  logic [1:0]        bresp
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CALC,
      S_ISSUE,
      S_HOLD,
      S_WAIT,
      S_DRAIN
   } state_t;

   state_t            state;
   state_t            next_state;

   logic [ADDR_W-1:0] cur_addr;
   logic [LEN_W-1:0]  remain;
   logic [LEN_W-1:0]  issued;
   logic [LEN_W-1:0]  acked;
   logic [LEN_W-1:0]  acked_next;

   logic [9:0]        to_4k;
   logic [4:0]        calc_len;
   logic [4:0]        cap_len;

   logic              accept;
   logic              zero_done;
   logic              launch;
   logic              finish;
   logic              count_b;
   logic              fifo_ok;

   assign busy = (state != S_IDLE);

   // Responses are counted in every active state; a stray bvalid while idle
   // must not disturb the counters of the next descriptor.
   assign count_b    = bvalid && (state != S_IDLE);
   assign acked_next = acked + LEN_W'(count_b);

   // Beats left before the next 4 KB page: 512 - addr[11:3], range 1..512.
   // The address is beat aligned so bits [2:0] play no part.
   assign to_4k = 10'd512 - {1'b0, cur_addr[11:3]};

   // eng_burst_len already holds the registered length while in ISSUE.
   assign fifo_ok = (32'(fifo_level) >= 32'(eng_burst_len));

   // Burst length is the smallest of: 16, beats to the page end, beats left.
   // Only the low five bits of the wider operands are taken once they are
   // known to be below 16.
   always_comb begin
      cap_len = 5'd16;
      if (to_4k < 10'd16) begin
         cap_len = to_4k[4:0];
      end
      calc_len = cap_len;
      if (remain < LEN_W'(cap_len)) begin
         calc_len = remain[4:0];
      end
   end

   // State register; reset drops straight back to IDLE, even mid-descriptor,
   // because the engine is reset by the same signal.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic plus the single-cycle control strobes. The launch
   // strobe is combinational so the burst leaves in the very cycle the
   // engine and FIFO conditions are met; HOLD follows so the engine's
   // stale eng_free from before the launch is never mistaken for completion.
   // DRAIN looks at acked_next so a response arriving in the DRAIN cycle
   // itself finishes the descriptor without an extra wait cycle.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      zero_done  = 1'b0;
      launch     = 1'b0;
      finish     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               if (total_beats != '0) begin
                  accept     = 1'b1;
                  next_state = S_CALC;
               end else begin
                  zero_done  = 1'b1;
               end
            end
         end
         S_CALC: begin
            next_state = S_ISSUE;
         end
         S_ISSUE: begin
            if (eng_free && fifo_ok) begin
               launch     = 1'b1;
               next_state = S_HOLD;
            end
         end
         S_HOLD: begin
            next_state = S_WAIT;
         end
         S_WAIT: begin
            if (eng_free) begin
               next_state = (remain != '0) ? S_CALC : S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (acked_next == issued) begin
               finish     = 1'b1;
               next_state = S_IDLE;
            end
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
      eng_valid = launch;
   end

   // Descriptor datapath. A new descriptor reloads the address and beat
   // count and clears the counters and the sticky error; starts arriving
   // while busy never reach here because accept is only raised in IDLE.
   // The burst head address and length are captured in CALC so they are
   // stable through ISSUE and keep their value after the launch, while
   // cur_addr/remain step forward on the launch itself.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         cur_addr      <= '0;
         remain        <= '0;
         issued        <= '0;
         acked         <= '0;
         err           <= 1'b0;
         done          <= 1'b0;
         eng_head_addr <= '0;
         eng_burst_len <= '0;
      end else begin
         done <= zero_done || finish;
         if (accept) begin
            cur_addr <= start_addr;
            remain   <= total_beats;
            issued   <= '0;
            acked    <= '0;
            err      <= 1'b0;
         end else begin
            if (state == S_CALC) begin
               eng_burst_len <= calc_len;
               eng_head_addr <= cur_addr;
            end
            if (launch) begin
               cur_addr <= cur_addr + ADDR_W'({eng_burst_len, 3'b000});
               remain   <= remain - LEN_W'(eng_burst_len);
               issued   <= issued + LEN_W'(1);
            end
            if (count_b) begin
               acked <= acked_next;
               if (bresp != 2'b00) begin
                  err <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mdma_write_sched.sv
// tb_mdma_write_sched
// Self-checking bench for mdma_write_sched. A behavioural write engine
// reacts to eng_valid (drops eng_free, raises it again later, returns a
// response). Expected bursts are pushed to a scoreboard when a descriptor
// is started and popped when the DUT launches a burst.
module tb_mdma_write_sched;

   logic        aclk = 1'b0;
   logic        areset;
   logic        start;
   logic [31:0] start_addr;
   logic [15:0] total_beats;
   logic        busy;
   logic        done;
   logic        err;
   logic        eng_valid;
   logic [31:0] eng_head_addr;
   logic [4:0]  eng_burst_len;
   logic        eng_free;
   logic [7:0]  fifo_level;
   logic        bvalid;
   logic [1:0]  bresp;

   mdma_write_sched #(
      .ADDR_W(32),
      .LEN_W (16),
      .LVL_W (8)
   ) dut (
      .aclk         (aclk),
      .areset       (areset),
      .start        (start),
      .start_addr   (start_addr),
      .total_beats  (total_beats),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .eng_valid    (eng_valid),
      .eng_head_addr(eng_head_addr),
      .eng_burst_len(eng_burst_len),
      .eng_free     (eng_free),
      .fifo_level   (fifo_level),
      .bvalid       (bvalid),
      .bresp        (bresp)
   );

   always #5 aclk = ~aclk;

   // Cycle index; read at the falling edge it names the current cycle.
   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   logic [31:0] exp_addr_q[$];
   logic [4:0]  exp_len_q[$];
   int          resp_due[$];
   logic [1:0]  resp_code_q[$];
   logic [1:0]  bresp_plan[$];

   bit   drop_next       = 1'b0;
   bit   prev_valid      = 1'b0;
   int   rise_cyc        = 0;
   int   eng_lat         = 3;
   int   resp_delay      = 2;
   int   valid_count     = 0;
   int   desc_base       = 0;
   int   first_valid_cyc = -1;
   int   done_seen       = 0;
   int   done_base       = 0;
   int   done_cyc        = -1;
   int   last_bvalid_cyc = -1;
   int   last_rise_cyc   = -1;
   int   start_cyc       = 0;
   logic busy_at_done    = 1'b0;
   logic err_at_done     = 1'b0;

   typedef struct {
      logic [31:0]      addr;
      logic [15:0]      beats;
      int               nb;
      logic [2:0][31:0] a;
      logic [2:0][4:0]  l;
   } vec_t;

   vec_t tbl[6];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic setEntry(input int i, input logic [31:0] addr, input logic [15:0] beats, input int nb,
                           input logic [31:0] a0, input logic [4:0] l0,
                           input logic [31:0] a1, input logic [4:0] l1,
                           input logic [31:0] a2, input logic [4:0] l2);
      tbl[i].addr  = addr;
      tbl[i].beats = beats;
      tbl[i].nb    = nb;
      tbl[i].a[0]  = a0;
      tbl[i].l[0]  = l0;
      tbl[i].a[1]  = a1;
      tbl[i].l[1]  = l1;
      tbl[i].a[2]  = a2;
      tbl[i].l[2]  = l2;
   endtask

   task automatic pushBurst(input logic [31:0] a, input logic [4:0] l);
      exp_addr_q.push_back(a);
      exp_len_q.push_back(l);
   endtask

   // Pulses start for one cycle and checks busy in the following cycle.
   task automatic applyStimulus(input logic [31:0] addr, input logic [15:0] beats, input logic exp_busy);
      @(negedge aclk);
      done_base   = done_seen;
      desc_base   = valid_count;
      start       = 1'b1;
      start_addr  = addr;
      total_beats = beats;
      start_cyc   = cyc;
      @(negedge aclk);
      start = 1'b0;
      #2;
      checkOutput("busy_after_start", 64'(busy), 64'(exp_busy));
   endtask

   task automatic waitDone();
      int n = 0;
      while (done_seen == done_base && n < 600) begin
         @(negedge aclk);
         #2;
         n++;
      end
      checkOutput("done_seen", 64'(done_seen != done_base), 64'd1);
   endtask

   // Behavioural write engine and output monitor. Inputs change on the
   // falling edge; outputs are sampled 1 ns later, after they settle.
   initial begin
      eng_free = 1'b1;
      bvalid   = 1'b0;
      bresp    = 2'b00;
      forever begin
         @(negedge aclk);
         bvalid = 1'b0;
         bresp  = 2'b00;
         if (resp_due.size() != 0 && resp_due[0] <= cyc) begin
            void'(resp_due.pop_front());
            bvalid          = 1'b1;
            bresp           = resp_code_q.pop_front();
            last_bvalid_cyc = cyc;
         end
         if (drop_next) begin
            eng_free  = 1'b0;
            drop_next = 1'b0;
         end else if (!eng_free && cyc >= rise_cyc) begin
            eng_free      = 1'b1;
            last_rise_cyc = cyc;
         end
         #1;
         if (!areset) begin
            if (eng_valid) begin
               checkOutput("valid_gap", 64'(prev_valid), 64'd0);
               if (valid_count == desc_base) first_valid_cyc = cyc;
               valid_count++;
               if (exp_addr_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL unexpected_burst: got addr 0x%0h len %0d, expected no burst",
                           eng_head_addr, eng_burst_len);
               end else begin
                  checkOutput("burst_addr", 64'(eng_head_addr), 64'(exp_addr_q.pop_front()));
                  checkOutput("burst_len", 64'(eng_burst_len), 64'(exp_len_q.pop_front()));
               end
               drop_next = 1'b1;
               rise_cyc  = cyc + 1 + eng_lat;
               resp_due.push_back(rise_cyc + resp_delay);
               if (bresp_plan.size() != 0) resp_code_q.push_back(bresp_plan.pop_front());
               else                        resp_code_q.push_back(2'b00);
            end
            if (done) begin
               done_seen++;
               done_cyc     = cyc;
               busy_at_done = busy;
               err_at_done  = err;
            end
         end
         prev_valid = eng_valid && !areset;
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int lvl_cyc;

      areset      = 1'b1;
      start       = 1'b0;
      start_addr  = '0;
      total_beats = '0;
      fifo_level  = 8'd64;

      setEntry(0, 32'h0000_1000, 16'd4,  1, 32'h0000_1000, 5'd4,  32'h0,         5'd0,  32'h0,         5'd0);
      setEntry(1, 32'h0000_0000, 16'd40, 3, 32'h0000_0000, 5'd16, 32'h0000_0080, 5'd16, 32'h0000_0100, 5'd8);
      setEntry(2, 32'h0000_0FC0, 16'd20, 2, 32'h0000_0FC0, 5'd8,  32'h0000_1000, 5'd12, 32'h0,         5'd0);
      setEntry(3, 32'h0000_0FF8, 16'd3,  2, 32'h0000_0FF8, 5'd1,  32'h0000_1000, 5'd2,  32'h0,         5'd0);
      setEntry(4, 32'hFFFF_FFF0, 16'd4,  2, 32'hFFFF_FFF0, 5'd2,  32'h0000_0000, 5'd2,  32'h0,         5'd0);
      setEntry(5, 32'h0000_2040, 16'd17, 2, 32'h0000_2040, 5'd16, 32'h0000_20C0, 5'd1,  32'h0,         5'd0);

      // Reset values
      repeat (3) @(negedge aclk);
      #1;
      checkOutput("rst_busy", 64'(busy), 64'd0);
      checkOutput("rst_done", 64'(done), 64'd0);
      checkOutput("rst_err", 64'(err), 64'd0);
      checkOutput("rst_eng_valid", 64'(eng_valid), 64'd0);
      checkOutput("rst_head_addr", 64'(eng_head_addr), 64'd0);
      checkOutput("rst_burst_len", 64'(eng_burst_len), 64'd0);
      @(negedge aclk);
      areset = 1'b0;

      // Table-driven descriptors with an idle engine and a full FIFO
      for (int i = 0; i < 6; i++) begin
         for (int b = 0; b < tbl[i].nb; b++) pushBurst(tbl[i].a[b], tbl[i].l[b]);
         applyStimulus(tbl[i].addr, tbl[i].beats, 1'b1);
         waitDone();
         checkOutput("burst_count", 64'(valid_count - desc_base), 64'(tbl[i].nb));
         checkOutput("scoreboard_empty", 64'(exp_addr_q.size()), 64'd0);
         checkOutput("first_latency", 64'(first_valid_cyc), 64'(start_cyc + 2));
         checkOutput("done_after_bvalid", 64'(done_cyc), 64'(last_bvalid_cyc + 1));
         checkOutput("err_at_done", 64'(err_at_done), 64'd0);
         checkOutput("busy_at_done", 64'(busy_at_done), 64'd0);
      end

      // Zero-length descriptor: done next cycle, never busy, no burst
      applyStimulus(32'h0000_7000, 16'd0, 1'b0);
      waitDone();
      checkOutput("zero_done_cycle", 64'(done_cyc), 64'(start_cyc + 1));
      checkOutput("zero_no_burst", 64'(valid_count - desc_base), 64'd0);

      // Final response arrives together with eng_free, before DRAIN
      resp_delay = 0;
      pushBurst(32'h0000_1000, 5'd4);
      applyStimulus(32'h0000_1000, 16'd4, 1'b1);
      waitDone();
      checkOutput("early_resp_done", 64'(done_cyc), 64'(last_rise_cyc + 2));
      resp_delay = 2;

      // FIFO gating: level 10 holds back a 16-beat burst
      @(negedge aclk);
      fifo_level = 8'd10;
      pushBurst(32'h0000_3000, 5'd16);
      applyStimulus(32'h0000_3000, 16'd16, 1'b1);
      repeat (20) @(negedge aclk);
      #2;
      checkOutput("gate_no_burst", 64'(valid_count - desc_base), 64'd0);
      @(negedge aclk);
      fifo_level = 8'd16;
      lvl_cyc    = cyc;
      waitDone();
      checkOutput("gate_release", 64'(first_valid_cyc), 64'(lvl_cyc));
      checkOutput("gate_scoreboard", 64'(exp_addr_q.size()), 64'd0);
      fifo_level = 8'd64;

      // Error response plus a start pulse while busy
      bresp_plan.push_back(2'b10);
      bresp_plan.push_back(2'b00);
      pushBurst(32'h0000_0000, 5'd16);
      pushBurst(32'h0000_0080, 5'd16);
      applyStimulus(32'h0000_0000, 16'd32, 1'b1);
      n = 0;
      while (valid_count == desc_base && n < 100) begin
         @(negedge aclk);
         #2;
         n++;
      end
      checkOutput("err_first_burst", 64'(valid_count - desc_base), 64'd1);
      @(negedge aclk);
      start       = 1'b1;
      start_addr  = 32'h0000_5000;
      total_beats = 16'd4;
      @(negedge aclk);
      start = 1'b0;
      waitDone();
      checkOutput("err_held_at_done", 64'(err_at_done), 64'd1);
      checkOutput("err_burst_count", 64'(valid_count - desc_base), 64'd2);
      checkOutput("err_scoreboard", 64'(exp_addr_q.size()), 64'd0);
      checkOutput("err_done_timing", 64'(done_cyc), 64'(last_bvalid_cyc + 1));
      #1;
      checkOutput("err_sticky_idle", 64'(err), 64'd1);
      pushBurst(32'h0000_1000, 5'd4);
      applyStimulus(32'h0000_1000, 16'd4, 1'b1);
      checkOutput("err_cleared", 64'(err), 64'd0);
      waitDone();
      checkOutput("err_clean_done", 64'(err_at_done), 64'd0);

      // Reset while waiting on burst 2 of 3
      eng_lat = 8;
      bresp_plan.push_back(2'b01);
      pushBurst(32'h0000_0000, 5'd16);
      pushBurst(32'h0000_0080, 5'd16);
      pushBurst(32'h0000_0100, 5'd8);
      applyStimulus(32'h0000_0000, 16'd40, 1'b1);
      n = 0;
      while (valid_count - desc_base < 2 && n < 200) begin
         @(negedge aclk);
         #2;
         n++;
      end
      checkOutput("rst_mid_second_burst", 64'(valid_count - desc_base), 64'd2);
      repeat (2) @(negedge aclk);
      #2;
      checkOutput("rst_mid_err_before", 64'(err), 64'd1);
      checkOutput("rst_mid_busy_before", 64'(busy), 64'd1);
      areset = 1'b1;
      #1;
      checkOutput("rst_mid_busy", 64'(busy), 64'd0);
      checkOutput("rst_mid_done", 64'(done), 64'd0);
      checkOutput("rst_mid_err", 64'(err), 64'd0);
      checkOutput("rst_mid_eng_valid", 64'(eng_valid), 64'd0);
      checkOutput("rst_mid_head_addr", 64'(eng_head_addr), 64'd0);
      checkOutput("rst_mid_burst_len", 64'(eng_burst_len), 64'd0);
      exp_addr_q.delete();
      exp_len_q.delete();
      resp_due.delete();
      resp_code_q.delete();
      bresp_plan.delete();
      drop_next = 1'b0;
      eng_free  = 1'b1;
      repeat (2) @(negedge aclk);
      areset  = 1'b0;
      eng_lat = 3;
      pushBurst(32'h0000_1000, 5'd4);
      applyStimulus(32'h0000_1000, 16'd4, 1'b1);
      waitDone();
      checkOutput("post_rst_burst_count", 64'(valid_count - desc_base), 64'd1);
      checkOutput("post_rst_scoreboard", 64'(exp_addr_q.size()), 64'd0);
      checkOutput("post_rst_err", 64'(err_at_done), 64'd0);

      repeat (5) @(negedge aclk);
      checkOutput("final_no_stray_burst", 64'(exp_addr_q.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
